// File: rtl/mesh_pkg.sv
// Shared packet layout and terminal-address helpers for mesh ingress adapters.
package mesh_pkg;

  localparam int unsigned NXT_W = 8;
  localparam int unsigned ROW_W = 4;
  localparam int unsigned COL_W = 4;
  localparam int unsigned HDR_W = NXT_W + ROW_W + COL_W + 1;

  // Field offsets measured down from the packet MSB.
  localparam int unsigned NXT_MSB_OFS     = 0;
  localparam int unsigned ROW_MSB_OFS     = 8;
  localparam int unsigned COL_MSB_OFS     = 12;
  localparam int unsigned MODE_MSB_OFS    = 16;
  localparam int unsigned PAYLOAD_MSB_OFS = 17;

  localparam logic [NXT_W-1:0] NXT_JUMP = 8'h00;

  // Edge terminals only: corners and interior router addresses are not terminals.
  function automatic logic is_terminal(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                                       input int unsigned rows, input int unsigned colums);
    int unsigned r;
    int unsigned c;
    r = 32'(row);
    c = 32'(col);
    if ((r == 0 || r == rows + 1) && c >= 1 && c <= colums) return 1'b1;
    if ((c == 0 || c == colums + 1) && r >= 1 && r <= rows) return 1'b1;
    return 1'b0;
  endfunction

endpackage

// File: rtl/mesh_src_fifo.sv
// Packet FIFO with a registered head output; head is zero whenever the FIFO is empty.
module mesh_src_fifo #(
  parameter int unsigned Width = 40,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             pushed_o,
  output logic             popped_o,
  output logic             pndng_o,
  output logic [Width-1:0] head_o
);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [PtrW:0]    count_q, count_d;
  logic [Width-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  assign full_o   = (count_q == (PtrW+1)'(Depth));
  assign pndng_o  = (count_q != '0);
  assign head_o   = head_q;
  assign pushed_o = push_ok;
  assign popped_o = pop_ok;
  assign rd_nxt   = rd_ptr_q + PtrW'(1);

  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && pndng_o;
    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_nxt : rd_ptr_q;
    count_d  = count_q + (PtrW+1)'(push_ok) - (PtrW+1)'(pop_ok);
    head_d   = head_q;
    // With one entry left a concurrent push feeds the head directly.
    if (pop_ok) begin
      if (count_q > (PtrW+1)'(1)) head_d = mem_q[rd_nxt];
      else if (push_ok)           head_d = wdata_i;
      else                        head_d = '0;
    end else if (!pndng_o && push_ok) begin
      head_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/mesh_term_src.sv
// Mesh terminal ingress: checks destination, assembles packets, buffers them for the router.
module mesh_term_src
  import mesh_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMS     = 4,
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4,
  parameter int unsigned SRC_ROW    = 0,
  parameter int unsigned SRC_COL    = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [3:0]         wr_row,
  input  logic [3:0]         wr_col,
  input  logic               wr_mode,
  input  logic [pckg_sz-18:0] wr_payload,
  output logic               full,
  output logic               pndng_i_in,
  output logic [pckg_sz-1:0] data_out_i_in,
  input  logic               popin,
  output logic [CNT_W-1:0]   sent_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic [CNT_W-1:0]   ovf_cnt
);
  logic               legal, pushed, popped;
  logic [pckg_sz-1:0] pkt;
  logic [CNT_W-1:0]   sent_cnt_q, sent_cnt_d, drop_cnt_q, drop_cnt_d, ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    legal = is_terminal(wr_row, wr_col, ROWS, COLUMS) &&
            !(wr_row == 4'(SRC_ROW) && wr_col == 4'(SRC_COL));
    pkt = '0;
    pkt[pckg_sz-1-NXT_MSB_OFS -: NXT_W]  = NXT_JUMP;
    pkt[pckg_sz-1-ROW_MSB_OFS -: ROW_W]  = wr_row;
    pkt[pckg_sz-1-COL_MSB_OFS -: COL_W]  = wr_col;
    pkt[pckg_sz-1-MODE_MSB_OFS]          = wr_mode;
    pkt[pckg_sz-1-PAYLOAD_MSB_OFS:0]     = wr_payload;
  end

  mesh_src_fifo #(
    .Width (pckg_sz),
    .Depth (fifo_depth)
  ) u_fifo (
    .clk_i    (clk),
    .rst_i    (reset),
    .push_i   (wr_en && legal),
    .wdata_i  (pkt),
    .pop_i    (popin),
    .full_o   (full),
    .pushed_o (pushed),
    .popped_o (popped),
    .pndng_o  (pndng_i_in),
    .head_o   (data_out_i_in)
  );

  // Counters saturate at all-ones; legality takes precedence over fullness.
  always_comb begin
    sent_cnt_d = sent_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (popped && sent_cnt_q != '1) sent_cnt_d = sent_cnt_q + CNT_W'(1);
    if (wr_en && !legal && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    if (wr_en && legal && !pushed && ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sent_cnt_q <= '0;
      drop_cnt_q <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      sent_cnt_q <= sent_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign sent_cnt = sent_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign ovf_cnt  = ovf_cnt_q;

endmodule

// File: tb/tb_mesh_term_src.sv
// Directed bench for mesh_term_src with a queue-based scoreboard of expected head packets.
module tb_mesh_term_src;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_row = '0;
  logic [3:0]  wr_col = '0;
  logic        wr_mode = 1'b0;
  logic [22:0] wr_payload = '0;
  logic        full, pndng_i_in, popin;
  logic [39:0] data_out_i_in;
  logic [15:0] sent_cnt, drop_cnt, ovf_cnt;

  logic [39:0] sb_q[$];
  int          exp_sent = 0, exp_drop = 0, exp_ovf = 0;
  int          errors = 0, checks = 0;

  mesh_term_src dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_row        (wr_row),
    .wr_col        (wr_col),
    .wr_mode       (wr_mode),
    .wr_payload    (wr_payload),
    .full          (full),
    .pndng_i_in    (pndng_i_in),
    .data_out_i_in (data_out_i_in),
    .popin         (popin),
    .sent_cnt      (sent_cnt),
    .drop_cnt      (drop_cnt),
    .ovf_cnt       (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic legal_dst(input int r, input int c);
    logic term;
    term = ((r == 0 || r == 5) && c >= 1 && c <= 4) || ((c == 0 || c == 5) && r >= 1 && r <= 4);
    return term && !(r == 0 && c == 1);
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".pndng"}, 64'(pndng_i_in), 64'(sb_q.size() != 0));
    check({tag, ".data"}, 64'(data_out_i_in), sb_q.size() != 0 ? 64'(sb_q[0]) : 64'd0);
    check({tag, ".full"}, 64'(full), 64'(sb_q.size() == 4));
    check({tag, ".sent"}, 64'(sent_cnt), 64'(exp_sent));
    check({tag, ".drop"}, 64'(drop_cnt), 64'(exp_drop));
    check({tag, ".ovf"}, 64'(ovf_cnt), 64'(exp_ovf));
  endtask

  // One clock: optional write and/or pop, scoreboard updated from pre-edge state.
  task automatic step(input string tag, input logic we, input int r, input int c,
                      input logic m, input logic [22:0] pl, input logic pop);
    logic [39:0] pkt;
    int          sz;
    @(negedge clk);
    wr_en = we; wr_row = 4'(r); wr_col = 4'(c); wr_mode = m; wr_payload = pl; popin = pop;
    pkt = {8'h00, 4'(r), 4'(c), m, pl};
    sz = sb_q.size();
    if (pop && sz != 0) begin
      check({tag, ".pophead"}, 64'(data_out_i_in), 64'(sb_q[0]));
      void'(sb_q.pop_front());
      exp_sent++;
    end
    if (we) begin
      if (!legal_dst(r, c)) exp_drop++;
      else if (sz == 4) exp_ovf++;
      else sb_q.push_back(pkt);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; popin = 1'b0;
    check_state(tag);
  endtask

  initial begin
    popin = 1'b0;
    reset = 1'b1;
    #12;
    check("rst.pndng", 64'(pndng_i_in), 64'd0);
    check("rst.data", 64'(data_out_i_in), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    check_state("rst");

    step("wr1", 1'b1, 5, 3, 1'b1, 23'h00ABC, 1'b0);
    check("wr1.pkt", 64'(data_out_i_in), 64'h00_5_3_8_00ABC);
    step("pop1", 1'b0, 0, 0, 1'b0, '0, 1'b1);

    step("bad22", 1'b1, 2, 2, 1'b0, 23'h1, 1'b0);
    step("bad00", 1'b1, 0, 0, 1'b0, 23'h2, 1'b0);
    step("badsrc", 1'b1, 0, 1, 1'b1, 23'h3, 1'b0);

    step("fill1", 1'b1, 5, 1, 1'b0, 23'h11111, 1'b0);
    step("fill2", 1'b1, 0, 4, 1'b1, 23'h22222, 1'b0);
    step("fill3", 1'b1, 3, 0, 1'b0, 23'h33333, 1'b0);
    step("fill4", 1'b1, 1, 5, 1'b1, 23'h44444, 1'b0);
    step("ovf5", 1'b1, 5, 4, 1'b0, 23'h55555, 1'b0);
    step("badfull", 1'b1, 5, 5, 1'b0, 23'h66666, 1'b0);
    step("ovfpop", 1'b1, 4, 0, 1'b0, 23'h77777, 1'b1);
    for (int i = 0; i < 3; i++) step("drain", 1'b0, 0, 0, 1'b0, '0, 1'b1);

    step("one", 1'b1, 2, 5, 1'b1, 23'h0BEEF, 1'b0);
    step("wrpop", 1'b1, 0, 3, 1'b0, 23'h0CAFE, 1'b1);
    step("popl", 1'b0, 0, 0, 1'b0, '0, 1'b1);

    for (int i = 0; i < 10; i++) step("idlepop", 1'b0, 0, 0, 1'b0, '0, 1'b1);

    step("pre1", 1'b1, 5, 2, 1'b0, 23'h0A1, 1'b0);
    step("pre2", 1'b1, 4, 5, 1'b1, 23'h0A2, 1'b0);
    step("pre3", 1'b1, 0, 2, 1'b0, 23'h0A3, 1'b0);
    step("bump", 1'b1, 1, 1, 1'b0, 23'h0A4, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    sb_q.delete();
    exp_sent = 0; exp_drop = 0; exp_ovf = 0;
    check_state("midrst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_state("postrst");
    step("after", 1'b1, 3, 5, 1'b1, 23'h12345, 1'b0);
    step("afterpop", 1'b0, 0, 0, 1'b0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
